typec_tx_sched: RTL and testbench

//  Packet scheduler in front of typec_tx. Arbitrates handshake, status (DLINK/DTYPE/DTEMP) and RAM-data requesters.

---
 rtl/typec_tx_sched.sv | 186 ++++++++++++++++++
 tb/tb_typec_tx_sched.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/typec_tx_sched.sv
// Packet scheduler in front of typec_tx: arbitrates handshake, status and RAM-data requesters,
// runs the fs/fd handshake and tracks the DATA0/DATA1 sequence toggle.
module typec_tx_sched #(
    parameter int          GAP_CYCLES = 4,
    parameter logic [11:0] FD_TIMEOUT = 12'hFFF,
    parameter logic [11:0] MAX_LEN    = 12'd1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        hs_req,
    input  logic [1:0]  hs_type,
    output logic        hs_done,
    input  logic [2:0]  stat_req,
    output logic [2:0]  stat_done,
    input  logic        data_req,
    input  logic [11:0] data_addr,
    input  logic [11:0] data_len_in,
    output logic        data_done,
    input  logic        data_seq_clr,
    output logic        tx_fs,
    input  logic        tx_fd,
    output logic [3:0]  tx_btype,
    output logic [11:0] tx_ram_addr,
    output logic [11:0] tx_data_len,
    output logic        busy,
    output logic        err
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_ARB     = 3'd1;
    localparam logic [2:0] S_LOAD    = 3'd2;
    localparam logic [2:0] S_SEND    = 3'd3;
    localparam logic [2:0] S_RELEASE = 3'd4;
    localparam logic [2:0] S_DONE    = 3'd5;
    localparam logic [2:0] S_GAP     = 3'd6;

    localparam logic [3:0] BAG_INIT  = 4'h0;
    localparam logic [3:0] BAG_ACK   = 4'h1;
    localparam logic [3:0] BAG_NAK   = 4'h2;
    localparam logic [3:0] BAG_STALL = 4'h3;
    localparam logic [3:0] BAG_DLINK = 4'h8;
    localparam logic [3:0] BAG_DTYPE = 4'h9;
    localparam logic [3:0] BAG_DTEMP = 4'hA;
    localparam logic [3:0] BAG_DATA0 = 4'hD;
    localparam logic [3:0] BAG_DATA1 = 4'hE;

    // One-hot grant: [0] hs, [1] DLINK, [2] DTYPE, [3] DTEMP, [4] data
    localparam int G_HS   = 0;
    localparam int G_DATA = 4;

    localparam int GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    logic [2:0]       state;
    logic [4:0]       grant;
    logic             abort;
    logic             reject;
    logic             toggle;
    logic [11:0]      to_cnt;
    logic [GAP_W-1:0] gap_cnt;

    logic             any_req;
    logic             toggle_eff;
    logic [11:0]      to_next;
    logic [3:0]       hs_btype;
    logic             in_done;

    assign any_req    = hs_req | (|stat_req) | data_req;
    assign toggle_eff = toggle & ~data_seq_clr;
    assign to_next    = (to_cnt == 12'hFFF) ? to_cnt : to_cnt + 12'd1;

    always_comb begin
        hs_btype = BAG_STALL;
        case (hs_type)
            2'd0:    hs_btype = BAG_ACK;
            2'd1:    hs_btype = BAG_NAK;
            default: hs_btype = BAG_STALL;
        endcase
    end

    // Sequence toggle: a clear always beats the flip of a completed data packet
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            toggle <= 1'b0;
        end else if (data_seq_clr) begin
            toggle <= 1'b0;
        end else if (state == S_DONE && grant[G_DATA] && !abort && !reject) begin
            toggle <= ~toggle;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            grant       <= 5'b0;
            abort       <= 1'b0;
            reject      <= 1'b0;
            to_cnt      <= 12'd0;
            gap_cnt     <= '0;
            tx_btype    <= BAG_INIT;
            tx_ram_addr <= 12'd0;
            tx_data_len <= 12'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (any_req) state <= S_ARB;
                end
                S_ARB: begin
                    abort       <= 1'b0;
                    reject      <= 1'b0;
                    tx_ram_addr <= 12'd0;
                    tx_data_len <= 12'd0;
                    state       <= S_LOAD;
                    if (hs_req) begin
                        grant    <= 5'b00001;
                        tx_btype <= hs_btype;
                    end else if (stat_req[0]) begin
                        grant    <= 5'b00010;
                        tx_btype <= BAG_DLINK;
                    end else if (stat_req[1]) begin
                        grant    <= 5'b00100;
                        tx_btype <= BAG_DTYPE;
                    end else if (stat_req[2]) begin
                        grant    <= 5'b01000;
                        tx_btype <= BAG_DTEMP;
                    end else if (data_req) begin
                        grant       <= 5'b10000;
                        tx_btype    <= toggle_eff ? BAG_DATA1 : BAG_DATA0;
                        tx_ram_addr <= data_addr;
                        tx_data_len <= data_len_in;
                    end else begin
                        // Requester withdrew between IDLE and ARB
                        grant <= 5'b0;
                        state <= S_IDLE;
                    end
                end
                S_LOAD: begin
                    to_cnt <= 12'd0;
                    if (grant[G_DATA] && (tx_data_len == 12'd0 || tx_data_len > MAX_LEN)) begin
                        reject <= 1'b1;
                        state  <= S_DONE;
                    end else begin
                        state <= S_SEND;
                    end
                end
                S_SEND: begin
                    to_cnt <= to_next;
                    if (tx_fd) begin
                        state <= S_RELEASE;
                    end else if (to_next >= FD_TIMEOUT) begin
                        abort <= 1'b1;
                        state <= S_RELEASE;
                    end
                end
                S_RELEASE: begin
                    if (abort || !tx_fd) state <= S_DONE;
                end
                S_DONE: begin
                    gap_cnt <= '0;
                    if (GAP_CYCLES > 0) begin
                        state <= S_GAP;
                    end else begin
                        state <= any_req ? S_ARB : S_IDLE;
                    end
                end
                S_GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        state <= any_req ? S_ARB : S_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign in_done   = (state == S_DONE);
    assign tx_fs     = (state == S_SEND);
    assign busy      = (state != S_IDLE);
    assign hs_done   = in_done & grant[G_HS];
    assign stat_done = {3{in_done}} & grant[3:1];
    assign data_done = in_done & grant[G_DATA];
    assign err       = in_done & (abort | reject);

endmodule

// File: tb/tb_typec_tx_sched.sv
// Directed bench for typec_tx_sched with a small typec_tx responder answering fs with fd.
module tb_typec_tx_sched;

    logic        clk;
    logic        rst_n;
    logic        hs_req;
    logic [1:0]  hs_type;
    logic        hs_done;
    logic [2:0]  stat_req;
    logic [2:0]  stat_done;
    logic        data_req;
    logic [11:0] data_addr;
    logic [11:0] data_len_in;
    logic        data_done;
    logic        data_seq_clr;
    logic        tx_fs;
    logic        tx_fd;
    logic [3:0]  tx_btype;
    logic [11:0] tx_ram_addr;
    logic [11:0] tx_data_len;
    logic        busy;
    logic        err;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int lat = 0;
    bit fd_en = 1'b1;

    int obs_btype, obs_addr, obs_len, obs_len0, obs_len_stable;
    int obs_fs_cycles, obs_first_fs_cyc, obs_done, obs_err, obs_done_cyc, obs_done_after;
    int prev_done;

    typec_tx_sched #(
        .GAP_CYCLES(4),
        .FD_TIMEOUT(12'd16),
        .MAX_LEN(12'd1024)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .hs_req(hs_req),
        .hs_type(hs_type),
        .hs_done(hs_done),
        .stat_req(stat_req),
        .stat_done(stat_done),
        .data_req(data_req),
        .data_addr(data_addr),
        .data_len_in(data_len_in),
        .data_done(data_done),
        .data_seq_clr(data_seq_clr),
        .tx_fs(tx_fs),
        .tx_fd(tx_fd),
        .tx_btype(tx_btype),
        .tx_ram_addr(tx_ram_addr),
        .tx_data_len(tx_data_len),
        .busy(busy),
        .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // typec_tx stand-in: raises fd on the third cycle of fs, drops it once fs falls
    initial begin
        tx_fd = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n || !tx_fs) begin
                tx_fd = 1'b0;
                lat = 0;
            end else if (fd_en && !tx_fd) begin
                lat++;
                if (lat >= 3) tx_fd = 1'b1;
            end
        end
    end

    task automatic checkOutput(input string tag, input int observed, input int expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input bit hs, input logic [1:0] hst, input logic [2:0] stat,
                                 input bit data, input logic [11:0] addr, input logic [11:0] len);
        hs_req      = hs;
        hs_type     = hst;
        stat_req    = stat;
        data_req    = data;
        data_addr   = addr;
        data_len_in = len;
    endtask

    // Follows one packet to its done pulse; drops the served request and optionally clears
    // the sequence toggle in the DONE cycle itself
    task automatic observePacket(input int bound, input bit clr_at_done);
        int n = 0;
        bit seen = 1'b0;
        obs_fs_cycles = 0;
        obs_first_fs_cyc = -1;
        obs_len_stable = 1;
        obs_len0 = 0;
        while (!seen && n < bound) begin
            @(negedge clk);
            n++;
            if (tx_fs) begin
                if (obs_fs_cycles == 0) begin
                    obs_first_fs_cyc = cyc;
                    obs_len0 = int'(tx_data_len);
                end else if (int'(tx_data_len) != obs_len0) begin
                    obs_len_stable = 0;
                end
                obs_fs_cycles++;
            end
            if (hs_done || stat_done != 3'b0 || data_done) begin
                seen = 1'b1;
                obs_done = int'({data_done, stat_done, hs_done});
                obs_err = int'(err);
                obs_btype = int'(tx_btype);
                obs_addr = int'(tx_ram_addr);
                obs_len = int'(tx_data_len);
                obs_done_cyc = cyc;
                if (hs_done) hs_req = 1'b0;
                stat_req = stat_req & ~stat_done;
                if (data_done) data_req = 1'b0;
                if (clr_at_done) data_seq_clr = 1'b1;
            end
        end
        checkOutput("packet_done_seen", int'(seen), 1);
        if (seen) begin
            @(negedge clk);
            obs_done_after = int'({data_done, stat_done, hs_done});
            data_seq_clr = 1'b0;
        end
    endtask

    task automatic waitIdle(input int bound);
        int n = 0;
        while (busy && n < bound) begin
            @(negedge clk);
            n++;
        end
        checkOutput("return_to_idle", int'(busy), 0);
    endtask

    initial begin
        int n;
        rst_n = 1'b0;
        data_seq_clr = 1'b0;
        applyStimulus(1'b0, 2'd0, 3'b000, 1'b0, 12'h0, 12'h0);
        repeat (3) @(negedge clk);

        checkOutput("reset_fs", int'(tx_fs), 0);
        checkOutput("reset_busy", int'(busy), 0);
        checkOutput("reset_btype", int'(tx_btype), 0);
        checkOutput("reset_dones", int'({data_done, stat_done, hs_done, err}), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // NAK handshake
        applyStimulus(1'b1, 2'd1, 3'b000, 1'b0, 12'h0, 12'h0);
        observePacket(40, 1'b0);
        checkOutput("nak_btype", obs_btype, 4'h2);
        checkOutput("nak_fs_cycles", obs_fs_cycles, 3);
        checkOutput("nak_done", obs_done, 5'b00001);
        checkOutput("nak_err", obs_err, 0);
        checkOutput("nak_single_pulse", obs_done_after, 0);
        checkOutput("nak_len_zero", obs_len, 0);
        waitIdle(20);

        // Reserved handshake type goes out as STALL
        applyStimulus(1'b1, 2'd3, 3'b000, 1'b0, 12'h0, 12'h0);
        observePacket(40, 1'b0);
        checkOutput("rsv_btype", obs_btype, 4'h3);
        waitIdle(20);

        // All three status requests held together
        applyStimulus(1'b0, 2'd0, 3'b111, 1'b0, 12'h0, 12'h0);
        observePacket(40, 1'b0);
        checkOutput("dlink_btype", obs_btype, 4'h8);
        checkOutput("dlink_done", obs_done, 5'b00010);
        prev_done = obs_done_cyc;
        observePacket(40, 1'b0);
        checkOutput("dtype_btype", obs_btype, 4'h9);
        checkOutput("dtype_done", obs_done, 5'b00100);
        checkOutput("gap_1", obs_first_fs_cyc - prev_done, 7);
        prev_done = obs_done_cyc;
        observePacket(40, 1'b0);
        checkOutput("dtemp_btype", obs_btype, 4'hA);
        checkOutput("dtemp_done", obs_done, 5'b01000);
        checkOutput("gap_2", obs_first_fs_cyc - prev_done, 7);
        waitIdle(20);

        // Data sequence toggle: D, E, D
        applyStimulus(1'b0, 2'd0, 3'b000, 1'b1, 12'h100, 12'd16);
        observePacket(40, 1'b0);
        checkOutput("data1_btype", obs_btype, 4'hD);
        checkOutput("data1_addr", obs_addr, 12'h100);
        checkOutput("data1_len", obs_len, 16);
        checkOutput("data1_len_stable", obs_len_stable, 1);
        checkOutput("data1_done", obs_done, 5'b10000);
        checkOutput("data1_err", obs_err, 0);
        applyStimulus(1'b0, 2'd0, 3'b000, 1'b1, 12'h100, 12'd16);
        observePacket(40, 1'b0);
        checkOutput("data2_btype", obs_btype, 4'hE);
        applyStimulus(1'b0, 2'd0, 3'b000, 1'b1, 12'h100, 12'd16);
        observePacket(40, 1'b0);
        checkOutput("data3_btype", obs_btype, 4'hD);
        waitIdle(20);

        // Idle clear, then a clear coinciding with the DONE flip
        data_seq_clr = 1'b1;
        @(negedge clk);
        data_seq_clr = 1'b0;
        applyStimulus(1'b0, 2'd0, 3'b000, 1'b1, 12'h100, 12'd16);
        observePacket(40, 1'b1);
        checkOutput("clr_idle_btype", obs_btype, 4'hD);
        applyStimulus(1'b0, 2'd0, 3'b000, 1'b1, 12'h100, 12'd16);
        observePacket(40, 1'b0);
        checkOutput("clr_done_btype", obs_btype, 4'hD);
        waitIdle(20);

        // Illegal lengths rejected without fs; toggle stays at DATA1
        applyStimulus(1'b0, 2'd0, 3'b000, 1'b1, 12'h100, 12'd0);
        observePacket(40, 1'b0);
        checkOutput("len0_done", obs_done, 5'b10000);
        checkOutput("len0_err", obs_err, 1);
        checkOutput("len0_no_fs", obs_fs_cycles, 0);
        applyStimulus(1'b0, 2'd0, 3'b000, 1'b1, 12'h100, 12'd1025);
        observePacket(40, 1'b0);
        checkOutput("len1025_err", obs_err, 1);
        checkOutput("len1025_no_fs", obs_fs_cycles, 0);
        applyStimulus(1'b0, 2'd0, 3'b000, 1'b1, 12'h040, 12'd1024);
        observePacket(40, 1'b0);
        checkOutput("len1024_btype", obs_btype, 4'hE);
        checkOutput("len1024_err", obs_err, 0);
        checkOutput("len1024_len", obs_len, 1024);
        waitIdle(20);

        // fd never arrives: abort after the timeout, retry keeps the PID
        fd_en = 1'b0;
        applyStimulus(1'b0, 2'd0, 3'b000, 1'b1, 12'h100, 12'd16);
        observePacket(80, 1'b0);
        checkOutput("timeout_fs_cycles", obs_fs_cycles, 16);
        checkOutput("timeout_done", obs_done, 5'b10000);
        checkOutput("timeout_err", obs_err, 1);
        checkOutput("timeout_btype", obs_btype, 4'hD);
        waitIdle(20);
        fd_en = 1'b1;
        applyStimulus(1'b0, 2'd0, 3'b000, 1'b1, 12'h100, 12'd16);
        observePacket(40, 1'b0);
        checkOutput("retry_btype", obs_btype, 4'hD);
        checkOutput("retry_err", obs_err, 0);
        waitIdle(20);

        // Reset in the middle of SEND with requests still pending
        applyStimulus(1'b1, 2'd0, 3'b000, 1'b1, 12'h200, 12'd8);
        n = 0;
        while (!tx_fs && n < 20) begin
            @(negedge clk);
            n++;
        end
        checkOutput("rst_fs_seen", int'(tx_fs), 1);
        checkOutput("rst_first_btype", int'(tx_btype), 4'h1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("rst_fs_drop", int'(tx_fs), 0);
        checkOutput("rst_busy", int'(busy), 0);
        checkOutput("rst_btype", int'(tx_btype), 0);
        checkOutput("rst_addr_len", int'({tx_ram_addr, tx_data_len}), 0);
        checkOutput("rst_dones", int'({data_done, stat_done, hs_done, err}), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        observePacket(40, 1'b0);
        checkOutput("rearb_hs_btype", obs_btype, 4'h1);
        checkOutput("rearb_hs_done", obs_done, 5'b00001);
        observePacket(40, 1'b0);
        checkOutput("rearb_data_btype", obs_btype, 4'hD);
        checkOutput("rearb_data_addr", obs_addr, 12'h200);
        checkOutput("rearb_data_len", obs_len, 8);
        waitIdle(20);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
